sobel_stream_param: RTL and testbench

//  Streaming 3x3 Sobel edge filter with FIFO interfaces on both sides. It sits between the grayscale FIFO and the output FIFO

---
 rtl/sobel_stream_param_if.sv | 24 ++
 rtl/sobel_stream_param.sv | 142 ++++++++++++++
 tb/tb_sobel_stream_param.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_param_if.sv
// FIFO-side signals of the Sobel stage: pixel source on one side, pixel sink on the other.
// The filter itself uses the slave view; whatever feeds and drains it uses the master view.
interface sobel_stream_param_if #(
  parameter int PIXEL_W = 8
);
  logic               in_empty;
  logic               in_rd_en;
  logic [PIXEL_W-1:0] in_dout;
  logic [PIXEL_W-1:0] threshold;
  logic               out_full;
  logic               out_wr_en;
  logic [PIXEL_W-1:0] out_din;
  logic               frame_done;

  modport master (
    output in_empty, in_dout, threshold, out_full,
    input  in_rd_en, out_wr_en, out_din, frame_done
  );

  modport slave (
    input  in_empty, in_dout, threshold, out_full,
    output in_rd_en, out_wr_en, out_din, frame_done
  );
endinterface

// File: rtl/sobel_stream_param.sv
// Streaming 3x3 Sobel filter between two FIFOs: two circular line buffers plus column registers
// form the window, so output k leaves in the cycle that input k+WIDTH+1 arrives.
module sobel_stream_param #(
  parameter int WIDTH   = 720,
  parameter int HEIGHT  = 540,
  parameter int PIXEL_W = 8,
  parameter int BINARY  = 0
) (
  input logic                clock,
  input logic                reset,
  sobel_stream_param_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GW = PIXEL_W + 3;
  localparam logic [CW-1:0]      LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0]      LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [RW-1:0]      ROW_ONE  = RW'(1);
  localparam logic [PIXEL_W-1:0] PIX_MAX  = '1;

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [CW-1:0]      in_col, out_col;
  logic [RW-1:0]      in_row, out_row;
  logic [PIXEL_W-1:0] thr;
  logic               done_pulse;
  logic [PIXEL_W-1:0] line1 [WIDTH];
  logic [PIXEL_W-1:0] line2 [WIDTH];
  logic [PIXEL_W-1:0] t1, t2, m1, m2, b1, b2;
  logic [PIXEL_W-1:0] t0, m0, new_px;
  logic               rd, wr, shift, last_in, last_out, border;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]      ax, ay;
  logic [GW:0]        mag;
  logic [PIXEL_W-1:0] pix_val;

  function automatic logic signed [GW-1:0] ext(input logic [PIXEL_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign last_in  = (in_row == LAST_ROW) && (in_col == LAST_COL);
  assign last_out = (out_row == LAST_ROW) && (out_col == LAST_COL);
  assign shift    = rd | wr;
  assign new_px   = (state == DRAIN) ? '0 : bus.in_dout;
  assign t0       = line2[in_col];
  assign m0       = line1[in_col];

  always_comb begin
    state_next = state;
    rd         = 1'b0;
    wr         = 1'b0;
    if (!reset) begin
      unique case (state)
        FILL: begin
          rd = !bus.in_empty;
          if (rd && in_row == ROW_ONE && in_col == '0) state_next = RUN;
        end
        RUN: begin
          rd = !bus.in_empty && !bus.out_full;
          wr = rd;
          if (rd && last_in) state_next = DRAIN;
        end
        DRAIN: begin
          wr = !bus.out_full;
          if (wr && last_out) state_next = FILL;
        end
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FILL;
      in_col     <= '0;
      in_row     <= '0;
      out_col    <= '0;
      out_row    <= '0;
      thr        <= '0;
      done_pulse <= 1'b0;
      t1 <= '0; t2 <= '0; m1 <= '0; m2 <= '0; b1 <= '0; b2 <= '0;
    end else begin
      state      <= state_next;
      done_pulse <= (state == DRAIN) && wr && last_out;
      if (state == FILL && rd && in_row == '0 && in_col == '0) thr <= bus.threshold;
      if (shift) begin
        b2 <= b1; b1 <= new_px;
        m2 <= m1; m1 <= m0;
        t2 <= t1; t1 <= t0;
        // Input counters double as the line-buffer pointer, so they restart with each frame.
        if (state == DRAIN && last_out) begin
          in_col <= '0;
          in_row <= '0;
        end else if (in_col == LAST_COL) begin
          in_col <= '0;
          in_row <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (wr) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (shift) begin
      line1[in_col] <= new_px;
      line2[in_col] <= line1[in_col];
    end
  end

  always_comb begin
    gx  = (ext(t0) + (ext(m0) <<< 1) + ext(new_px)) - (ext(t2) + (ext(m2) <<< 1) + ext(b2));
    gy  = (ext(b2) + (ext(b1) <<< 1) + ext(new_px)) - (ext(t2) + (ext(t1) <<< 1) + ext(t0));
    ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ({1'b0, ax} + {1'b0, ay}) >> 1;
  end

  always_comb begin
    pix_val = '0;
    border  = (out_row == '0) || (out_row == LAST_ROW) || (out_col == '0) || (out_col == LAST_COL);
    if (!border) begin
      if (BINARY != 0) pix_val = (mag > {4'b0000, thr}) ? PIX_MAX : '0;
      else             pix_val = (mag > {4'b0000, PIX_MAX}) ? PIX_MAX : mag[PIXEL_W-1:0];
    end
  end

  assign bus.in_rd_en   = rd;
  assign bus.out_wr_en  = wr;
  assign bus.out_din    = wr ? pix_val : '0;
  assign bus.frame_done = done_pulse;
endmodule

// File: tb/tb_sobel_stream_param.sv
// Bench for sobel_stream_param: magnitude and binary instances share one stimulus stream and are
// checked against a direct 3x3 Sobel model through a scoreboard queue.
module tb_sobel_stream_param;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int N  = W * H;

  typedef struct {
    logic [7:0] mag;
    logic [7:0] bin;
  } exp_t;

  typedef struct {
    int         pattern;
    logic [7:0] thr;
    bit         stall;
    int         nz_mag;
    int         nz_bin;
    string      name;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_empty, out_full;
  logic [7:0] in_dout, threshold;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   pix[H][W];
  int   wr_in_frame = 0, frames_done = 0, writes_total = 0, nz_mag = 0, nz_bin = 0;
  bit   done_due = 1'b0, tog = 1'b0;

  always #5 clock = ~clock;

  sobel_stream_param_if #(.PIXEL_W(PW)) bus_mag ();
  sobel_stream_param_if #(.PIXEL_W(PW)) bus_bin ();

  assign bus_mag.in_empty  = in_empty;
  assign bus_mag.in_dout   = in_dout;
  assign bus_mag.threshold = threshold;
  assign bus_mag.out_full  = out_full;
  assign bus_bin.in_empty  = in_empty;
  assign bus_bin.in_dout   = in_dout;
  assign bus_bin.threshold = threshold;
  assign bus_bin.out_full  = out_full;

  sobel_stream_param #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW), .BINARY(0)) dut_mag (
    .clock(clock), .reset(reset), .bus(bus_mag)
  );
  sobel_stream_param #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW), .BINARY(1)) dut_bin (
    .clock(clock), .reset(reset), .bus(bus_bin)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void build_frame(input int pattern);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pattern)
          0:       pix[r][c] = 100;
          1:       pix[r][c] = c * 10;
          2:       pix[r][c] = (c < 4) ? 0 : 255;
          default: pix[r][c] = int'($urandom_range(0, 255));
        endcase
  endfunction

  function automatic exp_t model(input int r, input int c, input logic [7:0] thr);
    exp_t e;
    int gx, gy, m;
    e.mag = 8'd0;
    e.bin = 8'd0;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return e;
    gx = (pix[r-1][c+1] + 2 * pix[r][c+1] + pix[r+1][c+1])
       - (pix[r-1][c-1] + 2 * pix[r][c-1] + pix[r+1][c-1]);
    gy = (pix[r+1][c-1] + 2 * pix[r+1][c] + pix[r+1][c+1])
       - (pix[r-1][c-1] + 2 * pix[r-1][c] + pix[r-1][c+1]);
    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
    e.bin = (m > int'(thr)) ? 8'd255 : 8'd0;
    e.mag = (m > 255) ? 8'd255 : 8'(m);
    return e;
  endfunction

  task automatic push_expected(input int count, input logic [7:0] thr);
    for (int k = 0; k < count; k++) sb.push_back(model(k / W, k % W, thr));
  endtask

  // Feeds npix pixels of pix[][], advancing only on cycles where the DUT actually reads.
  task automatic apply_stimulus(input int npix, input bit stall);
    int i = 0;
    int cyc = 0;
    while (i < npix && cyc < 4000) begin
      @(posedge clock); #1;
      in_dout  = 8'(pix[i / W][i % W]);
      in_empty = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      tog      = ~tog;
      out_full = stall ? tog : 1'b0;
      @(negedge clock);
      if (bus_mag.in_rd_en) i++;
      cyc++;
    end
    if (i < npix) check_output("feed_timeout", i, npix);
    @(posedge clock); #1;
    in_empty = 1'b1;
  endtask

  task automatic wait_frame(input bit stall, input int target);
    int cyc = 0;
    while (frames_done < target && cyc < 1000) begin
      @(posedge clock); #1;
      tog      = ~tog;
      out_full = stall ? tog : 1'b0;
      @(negedge clock);
      cyc++;
    end
    if (frames_done < target) check_output("frame_timeout", frames_done, target);
    out_full = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      wr_in_frame = 0;
      done_due    = 1'b0;
    end else begin
      if (done_due) begin
        check_output("frame_done_mag", bus_mag.frame_done, 1);
        check_output("frame_done_bin", bus_bin.frame_done, 1);
      end else if (bus_mag.frame_done || bus_bin.frame_done) begin
        check_output("spurious_frame_done", {bus_mag.frame_done, bus_bin.frame_done}, 0);
      end
      if (bus_mag.frame_done) frames_done++;
      done_due = 1'b0;
      if (bus_mag.out_wr_en || bus_bin.out_wr_en) begin
        check_output("wr_en_mag", bus_mag.out_wr_en, 1);
        check_output("wr_en_bin", bus_bin.out_wr_en, 1);
        if (sb.size() == 0) begin
          check_output("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("out_mag", bus_mag.out_din, e.mag);
          check_output("out_bin", bus_bin.out_din, e.bin);
        end
        if (bus_mag.out_din != 0) nz_mag++;
        if (bus_bin.out_din != 0) nz_bin++;
        writes_total++;
        wr_in_frame++;
        if (wr_in_frame == N) begin
          wr_in_frame = 0;
          done_due    = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check_output("reset_rd_en", {bus_mag.in_rd_en, bus_bin.in_rd_en}, 0);
    check_output("reset_wr_en", {bus_mag.out_wr_en, bus_bin.out_wr_en}, 0);
    check_output("reset_out_din", {bus_mag.out_din, bus_bin.out_din}, 0);
    check_output("reset_frame_done", {bus_mag.frame_done, bus_bin.frame_done}, 0);
  endtask

  initial begin
    #400000;
    check_output("watchdog", 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vec_t vecs[6];
    int   fd0, wt0;
    vecs[0] = '{0, 8'd30,  1'b0, 0,  0,  "T1_flat"};
    vecs[1] = '{1, 8'd30,  1'b0, 24, 24, "T2_ramp_thr30"};
    vecs[2] = '{1, 8'd40,  1'b0, 24, 0,  "T4_ramp_thr40"};
    vecs[3] = '{2, 8'd30,  1'b0, 8,  8,  "T3_step"};
    vecs[4] = '{2, 8'd30,  1'b1, 8,  8,  "T5_step_stall"};
    vecs[5] = '{3, 8'd100, 1'b1, -1, -1, "random_stall"};

    reset = 1'b1; in_empty = 1'b0; out_full = 1'b0; in_dout = 8'd0; threshold = 8'd30;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock); #1;
    reset = 1'b0; in_empty = 1'b1;

    for (int v = 0; v < 6; v++) begin
      build_frame(vecs[v].pattern);
      threshold = vecs[v].thr;
      nz_mag = 0; nz_bin = 0;
      fd0 = frames_done; wt0 = writes_total;
      push_expected(N, vecs[v].thr);
      apply_stimulus(N, vecs[v].stall);
      wait_frame(vecs[v].stall, fd0 + 1);
      check_output({vecs[v].name, "_count"}, writes_total - wt0, N);
      if (vecs[v].nz_mag >= 0) begin
        check_output({vecs[v].name, "_nz_mag"}, nz_mag, vecs[v].nz_mag);
        check_output({vecs[v].name, "_nz_bin"}, nz_bin, vecs[v].nz_bin);
      end
      check_output({vecs[v].name, "_sb_empty"}, sb.size(), 0);
    end

    // Abort a frame after 20 pixels (11 outputs already written), then restart cleanly.
    build_frame(1);
    threshold = 8'd30;
    push_expected(11, 8'd30);
    apply_stimulus(20, 1'b0);
    reset = 1'b1; in_empty = 1'b0;
    @(negedge clock);
    check_reset_outputs();
    check_output("abort_sb_empty", sb.size(), 0);
    @(posedge clock); #1;
    reset = 1'b0; in_empty = 1'b1;

    // Ramp then step back-to-back; the threshold change lands mid-frame and must not affect the ramp.
    fd0 = frames_done; wt0 = writes_total;
    build_frame(1);
    push_expected(N, 8'd30);
    apply_stimulus(N, 1'b0);
    build_frame(2);
    threshold = 8'd200;
    push_expected(N, 8'd200);
    apply_stimulus(N, 1'b0);
    wait_frame(1'b0, fd0 + 2);
    check_output("T6_count", writes_total - wt0, 2 * N);
    check_output("T6_sb_empty", sb.size(), 0);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
